// File: rtl/axilite_structure_if.sv
// AXI4-Lite bus bundle shared by the bridge and its upstream master.
interface axi4_Lite #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [addrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   wvalid;
    logic                   wready;
    logic [dataWidth-1:0]   wdata;
    logic [dataWidth/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [addrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   rvalid;
    logic                   rready;
    logic [dataWidth-1:0]   rdata;
    logic [1:0]             rresp;

    modport axiSlave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport axiMaster (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_structure.sv
// AXI4-Lite slave that registers each request toward a downstream port and
// relays the downstream response; independent write and read FSMs.
module axilite_structure #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4_Lite.axiSlave             i_f,
    input  logic                   awreadyM,
    input  logic                   wreadyM,
    input  logic                   arreadyM,
    input  logic                   bvalidM,
    input  logic                   rvalidM,
    input  logic [1:0]             brespM,
    input  logic [dataWidth-1:0]   rdataM,
    input  logic [1:0]             rrespM,
    output logic [addrWidth-1:0]   awaddrM,
    output logic [2:0]             awprotM,
    output logic [dataWidth-1:0]   wdataM,
    output logic [dataWidth/8-1:0] wstrbM,
    output logic [addrWidth-1:0]   araddrM,
    output logic [2:0]             arprotM
);

    typedef enum logic [2:0] {
        W_IDLE, W_ADDR, W_DATA, W_DWAIT, W_BWAIT, W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE, R_ADDR, R_DATA, R_RESP
    } r_state_e;

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic [addrWidth-1:0]   awaddr_q, awaddr_d;
    logic [2:0]             awprot_q, awprot_d;
    logic [dataWidth-1:0]   wdata_q, wdata_d;
    logic [dataWidth/8-1:0] wstrb_q, wstrb_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [addrWidth-1:0]   araddr_q, araddr_d;
    logic [2:0]             arprot_q, arprot_d;
    logic [dataWidth-1:0]   rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            awprot_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            araddr_q  <= '0;
            arprot_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            awprot_q  <= awprot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // NOTE: every variable gets a hold default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awprot_d  = awprot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: if (i_f.awvalid) begin
                awaddr_d  = i_f.awaddr;
                awprot_d  = i_f.awprot;
                w_state_d = W_ADDR;
            end
            W_ADDR:  if (awreadyM) w_state_d = W_DATA;
            W_DATA: if (i_f.wvalid) begin
                wdata_d   = i_f.wdata;
                wstrb_d   = i_f.wstrb;
                w_state_d = W_DWAIT;
            end
            W_DWAIT: if (wreadyM) w_state_d = W_BWAIT;
            W_BWAIT: if (bvalidM) begin
                bresp_d   = brespM;
                w_state_d = W_RESP;
            end
            W_RESP:  if (i_f.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (i_f.arvalid) begin
                araddr_d  = i_f.araddr;
                arprot_d  = i_f.arprot;
                r_state_d = R_ADDR;
            end
            R_ADDR:  if (arreadyM) r_state_d = R_DATA;
            R_DATA: if (rvalidM) begin
                rdata_d   = rdataM;
                rresp_d   = rrespM;
                r_state_d = R_RESP;
            end
            R_RESP:  if (i_f.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so they never glitch on inputs.
    assign i_f.awready = (w_state_q == W_IDLE);
    assign i_f.wready  = (w_state_q == W_DATA);
    assign i_f.bvalid  = (w_state_q == W_RESP);
    assign i_f.bresp   = bresp_q;
    assign i_f.arready = (r_state_q == R_IDLE);
    assign i_f.rvalid  = (r_state_q == R_RESP);
    assign i_f.rdata   = rdata_q;
    assign i_f.rresp   = rresp_q;

    assign awaddrM = awaddr_q;
    assign awprotM = awprot_q;
    assign wdataM  = wdata_q;
    assign wstrbM  = wstrb_q;
    assign araddrM = araddr_q;
    assign arprotM = arprot_q;

endmodule

// File: tb/tb_axilite_structure.sv
// Randomized bench for axilite_structure: drives upstream/downstream handshakes
// and compares against a transaction-level model of the last accepted values.
module tb_axilite_structure;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0]   awaddr;
        logic [2:0]      awprot;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
        logic [1:0]      bresp;
        logic [AW-1:0]   araddr;
        logic [2:0]      arprot;
        logic [DW-1:0]   rdata;
        logic [1:0]      rresp;
    } model_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            awreadyM, wreadyM, arreadyM, bvalidM, rvalidM;
    logic [1:0]      brespM, rrespM;
    logic [DW-1:0]   rdataM;
    logic [AW-1:0]   awaddrM, araddrM;
    logic [2:0]      awprotM, arprotM;
    logic [DW-1:0]   wdataM;
    logic [DW/8-1:0] wstrbM;

    model_t mdl;
    int     n_tests = 0;
    int     n_fail  = 0;

    axi4_Lite #(.addrWidth(AW), .dataWidth(DW)) bus ();

    axilite_structure #(.addrWidth(AW), .dataWidth(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_f      (bus),
        .awreadyM (awreadyM),
        .wreadyM  (wreadyM),
        .arreadyM (arreadyM),
        .bvalidM  (bvalidM),
        .rvalidM  (rvalidM),
        .brespM   (brespM),
        .rdataM   (rdataM),
        .rrespM   (rrespM),
        .awaddrM  (awaddrM),
        .awprotM  (awprotM),
        .wdataM   (wdataM),
        .wstrbM   (wstrbM),
        .araddrM  (araddrM),
        .arprotM  (arprotM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [2:0] p, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s, input logic [1:0] r, input int dly);
        check("w_awready_idle", bus.awready, 1);
        bus.awvalid = 1; bus.awaddr = a; bus.awprot = p;
        step();
        bus.awvalid = 0; bus.awaddr = $urandom; bus.awprot = ~p;
        mdl.awaddr = a; mdl.awprot = p;
        check("w_awaddrM", awaddrM, mdl.awaddr);
        check("w_awprotM", awprotM, mdl.awprot);
        check("w_awready_busy", bus.awready, 0);
        repeat (dly) begin
            step();
            check("w_stall_wready", bus.wready, 0);
            check("w_stall_awaddrM", awaddrM, mdl.awaddr);
        end
        awreadyM = 1; step(); awreadyM = 0;
        check("w_wready", bus.wready, 1);
        bus.wvalid = 1; bus.wdata = d; bus.wstrb = s;
        step();
        bus.wvalid = 0; bus.wdata = ~d; bus.wstrb = ~s;
        mdl.wdata = d; mdl.wstrb = s;
        check("w_wdataM", wdataM, mdl.wdata);
        check("w_wstrbM", wstrbM, mdl.wstrb);
        check("w_wready_drop", bus.wready, 0);
        repeat (dly) step();
        wreadyM = 1; step(); wreadyM = 0;
        repeat (dly) begin
            check("w_bvalid_wait", bus.bvalid, 0);
            step();
        end
        bvalidM = 1; brespM = r;
        step();
        bvalidM = 0; brespM = ~r;
        mdl.bresp = r;
        check("w_bvalid", bus.bvalid, 1);
        check("w_bresp", bus.bresp, mdl.bresp);
        repeat (dly) begin
            step();
            check("w_bvalid_hold", bus.bvalid, 1);
        end
        bus.bready = 1; step(); bus.bready = 0;
        check("w_bvalid_drop", bus.bvalid, 0);
        check("w_awready_back", bus.awready, 1);
        check("w_bresp_hold", bus.bresp, mdl.bresp);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [2:0] p, input logic [DW-1:0] d,
                           input logic [1:0] r, input int dly);
        check("r_arready_idle", bus.arready, 1);
        bus.arvalid = 1; bus.araddr = a; bus.arprot = p;
        step();
        bus.arvalid = 0; bus.araddr = $urandom; bus.arprot = ~p;
        mdl.araddr = a; mdl.arprot = p;
        check("r_araddrM", araddrM, mdl.araddr);
        check("r_arprotM", arprotM, mdl.arprot);
        check("r_arready_busy", bus.arready, 0);
        repeat (dly) begin
            step();
            check("r_stall_araddrM", araddrM, mdl.araddr);
        end
        arreadyM = 1; step(); arreadyM = 0;
        repeat (dly) begin
            check("r_rvalid_wait", bus.rvalid, 0);
            step();
        end
        rvalidM = 1; rdataM = d; rrespM = r;
        step();
        rvalidM = 0; rdataM = ~d; rrespM = ~r;
        mdl.rdata = d; mdl.rresp = r;
        check("r_rvalid", bus.rvalid, 1);
        check("r_rdata", bus.rdata, mdl.rdata);
        check("r_rresp", bus.rresp, mdl.rresp);
        repeat (dly) begin
            step();
            check("r_rvalid_hold", bus.rvalid, 1);
        end
        bus.rready = 1; step(); bus.rready = 0;
        check("r_rvalid_drop", bus.rvalid, 0);
        check("r_arready_back", bus.arready, 1);
        check("r_rdata_hold", bus.rdata, mdl.rdata);
    endtask

    task automatic clear_model();
        mdl.awaddr = '0; mdl.awprot = '0; mdl.wdata = '0; mdl.wstrb = '0; mdl.bresp = '0;
        mdl.araddr = '0; mdl.arprot = '0; mdl.rdata = '0; mdl.rresp = '0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_awaddrM"}, awaddrM, mdl.awaddr);
        check({tag, "_wdataM"},  wdataM,  mdl.wdata);
        check({tag, "_wstrbM"},  wstrbM,  mdl.wstrb);
        check({tag, "_araddrM"}, araddrM, mdl.araddr);
        check({tag, "_bresp"},   bus.bresp, mdl.bresp);
        check({tag, "_rdata"},   bus.rdata, mdl.rdata);
        check({tag, "_rresp"},   bus.rresp, mdl.rresp);
    endtask

    initial begin
        rst = 1;
        awreadyM = 0; wreadyM = 0; arreadyM = 0; bvalidM = 0; rvalidM = 0;
        brespM = 0; rrespM = 0; rdataM = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
        clear_model();
        repeat (2) step();
        rst = 0;
        step();

        check("rst_awready", bus.awready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check_regs("rst");

        do_write(32'h1234_5678, 3'd0, 32'hDEAD_BEEF, 4'hF, 2'd0, 1);
        do_read(32'h0000_0040, 3'd0, 32'hCAFE_F00D, 2'd1, 1);
        do_write($urandom, 3'($urandom), $urandom, 4'($urandom), 2'($urandom), 10);

        fork
            do_write($urandom, 3'($urandom), $urandom, 4'($urandom), 2'($urandom), 2);
            do_read($urandom, 3'($urandom), $urandom, 2'($urandom), 3);
        join

        for (int i = 0; i < 3; i++)
            do_write($urandom, 3'($urandom), $urandom, 4'($urandom), 2'($urandom),
                     int'($urandom_range(4, 1)));
        for (int i = 0; i < 3; i++)
            do_read($urandom, 3'($urandom), $urandom, 2'($urandom),
                    int'($urandom_range(4, 1)));

        // Downstream strobes while idle must be ignored.
        awreadyM = 1; wreadyM = 1; arreadyM = 1; bvalidM = 1; rvalidM = 1;
        brespM = ~mdl.bresp; rrespM = ~mdl.rresp; rdataM = ~mdl.rdata;
        repeat (2) step();
        check("idle_bvalid", bus.bvalid, 0);
        check("idle_rvalid", bus.rvalid, 0);
        check("idle_awready", bus.awready, 1);
        check("idle_arready", bus.arready, 1);
        check_regs("idle");
        awreadyM = 0; wreadyM = 0; arreadyM = 0; bvalidM = 0; rvalidM = 0;

        // Drive a write into W_BWAIT, then reset it.
        bus.awvalid = 1; bus.awaddr = 32'hA5A5_0F0F; step(); bus.awvalid = 0;
        awreadyM = 1; step(); awreadyM = 0;
        bus.wvalid = 1; bus.wdata = 32'h1357_9BDF; bus.wstrb = 4'h3; step(); bus.wvalid = 0;
        wreadyM = 1; step(); wreadyM = 0;
        check("bwait_awaddrM", awaddrM, 32'hA5A5_0F0F);
        check("bwait_bvalid", bus.bvalid, 0);
        bvalidM = 1;
        rst = 1; step(); rst = 0; bvalidM = 0;
        clear_model();
        check("midrst_bvalid", bus.bvalid, 0);
        check("midrst_awready", bus.awready, 1);
        check("midrst_wready", bus.wready, 0);
        check_regs("midrst");
        step();
        check("midrst_idle_awready", bus.awready, 1);
        check("midrst_idle_bvalid", bus.bvalid, 0);

        do_write($urandom, 3'($urandom), $urandom, 4'($urandom), 2'($urandom), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axilite_structure.md
AXILITE_STRUCTURE -- requirements
Module: axilite_structure

Interface
REQ-001 Parameters SHALL be: addrWidth, default 32, address width; dataWidth, default 32, data width (multiple of 8).
REQ-002 One clock; reset is synchronous and active-high; ports SHALL be named clk and rst.
REQ-003 Port clk  input  1  rising-edge clock for all logic.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port i_f  axi4_Lite interface, axiSlave modport  AXI4-Lite slave side.
- Inputs awvalid, awaddr[addrWidth], awprot[3], wvalid, wdata[dataWidth], wstrb[dataWidth/8], bready, arvalid, araddr[addrWidth], arprot[3], rready.
- Outputs awready, wready, bvalid, bresp[2], arready, rvalid, rdata[dataWidth], rresp[2].
REQ-006 Downstream inputs SHALL be: awreadyM, wreadyM, arreadyM, bvalidM, rvalidM (1 bit each); brespM[2]; rdataM[dataWidth]; rrespM[2].
REQ-007 Downstream outputs SHALL be: awaddrM[addrWidth], awprotM[3], wdataM[dataWidth], wstrbM[dataWidth/8], araddrM[addrWidth], arprotM[3].
REQ-008 Port order SHALL be: clk, rst, i_f, then REQ-006 inputs, then REQ-007 outputs, in the order listed.

Function
REQ-009 Write and read channels SHALL be independent FSMs that operate concurrently without interaction.
REQ-010 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_DWAIT, W_BWAIT, W_RESP.
- awready=1 only in W_IDLE.
- wready=1 only in W_DATA.
- bvalid=1 only in W_RESP.
REQ-011 W_IDLE: on awvalid, register awaddr->awaddrM and awprot->awprotM, then go to W_ADDR.
REQ-012 W_ADDR: awreadyM=1 -> W_DATA; otherwise hold.
REQ-013 W_DATA: on wvalid, register wdata->wdataM and wstrb->wstrbM, then go to W_DWAIT.
REQ-014 W_DWAIT: wreadyM=1 -> W_BWAIT.
REQ-015 W_BWAIT: bvalidM=1 -> capture brespM into bresp, go to W_RESP.
REQ-016 W_RESP: bvalid=1 with registered bresp; bready=1 -> W_IDLE.
REQ-017 Read FSM states: R_IDLE, R_ADDR, R_DATA, R_RESP.
- arready=1 only in R_IDLE.
- rvalid=1 only in R_RESP.
REQ-018 R_IDLE: on arvalid, register araddr->araddrM and arprot->arprotM, then go to R_ADDR.
REQ-019 R_ADDR: arreadyM=1 -> R_DATA.
REQ-020 R_DATA: rvalidM=1 -> capture rdataM->rdata and rrespM->rresp, go to R_RESP.
REQ-021 R_RESP: rvalid=1; rready=1 -> R_IDLE.
REQ-022 All state transitions and captures SHALL occur on the clk edge where the qualifying condition is sampled high.
- Minimum latency from handshake to next-state output change is 1 cycle.
- Each wait state holds indefinitely while its condition stays low.
REQ-023 Registered downstream outputs and response registers SHALL hold their values until the next capture.
- Upstream deassertion of awvalid, wvalid or arvalid does not change them.
REQ-024 Downstream inputs sampled outside their wait state SHALL be ignored.
- Example: awreadyM in W_IDLE.
- Example: rvalidM in R_IDLE.
REQ-025 Only one write and one read transaction SHALL be outstanding at a time; no new AW/AR is accepted until return to the corresponding IDLE.
REQ-026 bresp and rresp codes SHALL be passed through unmodified; no decoding or error generation.

Reset
REQ-027 While rst=1 at a clk edge, both FSMs SHALL go to W_IDLE/R_IDLE.
REQ-028 On reset, awaddrM, awprotM, wdataM, wstrbM, araddrM, arprotM, bresp, rdata and rresp SHALL clear to 0.
REQ-029 After reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no response issued; the first cycle after reset is idle.

Verification
REQ-031 Write:
- Stimulus: awvalid with awaddr=0x1234_5678, then awreadyM=1; wvalid with wdata=0xDEAD_BEEF, wstrb=0xF, then wreadyM=1; bvalidM=1 with brespM=0; bready=1.
- Response: awaddrM=0x12345678, wdataM=0xDEADBEEF, bvalid=1 with bresp=0, return to awready=1.
REQ-032 Read:
- Stimulus: arvalid with araddr=0x0000_0040, then arreadyM=1; rvalidM=1 with rdataM=0xCAFE_F00D, rrespM=1; rready=1.
- Response: araddrM=0x40, rvalid=1 with rdata=0xCAFEF00D, rresp=1; rvalid drops 1 cycle after rready.
REQ-033 Stall: hold awreadyM=0 for 10 cycles -> FSM stays in W_ADDR, wready=0, awaddrM stable.
REQ-034 Concurrency: a write and a read issued in the same cycle -> both complete correctly and independently.
REQ-035 Mid-operation reset: rst=1 in W_BWAIT -> next cycle bvalid=0, awready=1, awaddrM=0.
REQ-036 Back-to-back: 3 writes then 3 reads with random addresses/data and random 1-4 cycle downstream delays -> every response matches its captured value.
